// File: rtl/cordic_rect_to_polar.sv
// cordic_rect_to_polar: iterative CORDIC vectoring (x, y) -> (magnitude, angle); CORDIC_GAIN_COMP_EN adds the 1/K gain stage
module cordic_rect_to_polar #(
    parameter int INTEGER_BITS    = 3,
    parameter int FRACTIONAL_BITS = 30,
    parameter int N_ITERATION     = FRACTIONAL_BITS,
    localparam int BITS = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [BITS-1:0] i_x,
    input  logic [BITS-1:0] i_y,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BITS-1:0] o_mag,
    output logic [BITS-1:0] o_angle
);
    localparam int W  = BITS + 2;
    localparam int CW = $clog2(N_ITERATION + 1);
    typedef logic signed [W-1:0] word_t;
    localparam word_t PI      = word_t'(3.14159265358979323846 * (2.0 ** FRACTIONAL_BITS));
    localparam word_t MAG_MAX = (word_t'(1) <<< (BITS - 1)) - word_t'(1);
`ifdef CORDIC_GAIN_COMP_EN
    typedef logic signed [2*W-1:0] wide_t;
    localparam word_t KINV = word_t'(0.6072529350 * (2.0 ** FRACTIONAL_BITS));
`endif
    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;
    state_t state, state_nx;
    word_t x, y, z, xs, ys;
    word_t atan_lut [N_ITERATION];
    logic [CW-1:0] i;
    logic last, zero;
    genvar k;
    for (k = 0; k < N_ITERATION; k++) begin : g_atan
        assign atan_lut[k] = word_t'($atan(2.0 ** (-k)) * (2.0 ** FRACTIONAL_BITS));
    end
    assign xs      = x >>> i;
    assign ys      = y >>> i;
    assign last    = i == CW'(N_ITERATION - 1);
    // an all-zero vector never rotates, so its angle must not accumulate
    assign zero    = x == '0 && y == '0;
    assign o_ready = state == IDLE;
    assign o_valid = state == DONE;
    assign o_mag   = x > MAG_MAX ? MAG_MAX[BITS-1:0] : x[BITS-1:0];
    assign o_angle = z[BITS-1:0];
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // sequencing: capture, fold, iterate, optional compensation, hold result
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = i_valid ? PRE : IDLE;
            PRE:  state_nx = ITER;
`ifdef CORDIC_GAIN_COMP_EN
            ITER: state_nx = last ? POST : ITER;
            POST: state_nx = DONE;
`else
            ITER: state_nx = last ? DONE : ITER;
`endif
            DONE: state_nx = i_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // datapath: sign-extended capture, left-half fold, micro-rotations, gain scaling
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x <= '0;
            y <= '0;
            z <= '0;
            i <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    x <= word_t'($signed(i_x));
                    y <= word_t'($signed(i_y));
                end
                PRE: begin
                    x <= x[W-1] ? -x : x;
                    y <= x[W-1] ? -y : y;
                    z <= x[W-1] ? (y[W-1] ? -PI : PI) : '0;
                    i <= '0;
                end
                ITER: begin
                    x <= y[W-1] ? x - ys : x + ys;
                    y <= y[W-1] ? y + xs : y - xs;
                    z <= zero ? z : (y[W-1] ? z - atan_lut[i] : z + atan_lut[i]);
                    i <= i + CW'(1);
                end
`ifdef CORDIC_GAIN_COMP_EN
                POST: x <= word_t'((wide_t'(x) * wide_t'(KINV) + (wide_t'(1) <<< (FRACTIONAL_BITS - 1))) >>> FRACTIONAL_BITS);
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_rect_to_polar.sv
// tb_cordic_rect_to_polar: vector table, random vectors against a trig model, backpressure and reset sequences
module tb_cordic_rect_to_polar;
    localparam int IB = 3;
    localparam int FB = 30;
    localparam int N = FB;
    localparam int BITS = IB + FB;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif
    localparam real SCALE = 2.0 ** FB;
    localparam real MAXR = (2.0 ** (BITS - 1) - 1.0) / SCALE;
    localparam real PI_R = 3.14159265358979323846;
    localparam real TOL = 0.001;

    typedef struct { real x; real y; real ang; real mag; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic src_valid = 1'b0;
    logic src_ready;
    logic [BITS-1:0] src_x = '0;
    logic [BITS-1:0] src_y = '0;
    logic res_valid;
    logic res_ready = 1'b0;
    logic [BITS-1:0] res_mag, res_angle;
    int checks = 0;
    int failures = 0;
    real gain;

    cordic_rect_to_polar dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(src_valid), .o_ready(src_ready),
        .i_x(src_x), .i_y(src_y), .o_valid(res_valid), .i_ready(res_ready),
        .o_mag(res_mag), .o_angle(res_angle)
    );

    always #5 clk = ~clk;

    function automatic logic [BITS-1:0] to_q(input real v);
        longint t;
        t = longint'(v * SCALE);
        return t[BITS-1:0];
    endfunction

    function automatic real q2r(input logic [BITS-1:0] q);
        longint t;
        t = longint'($signed(q));
        return real'(t) / SCALE;
    endfunction

    function automatic real q2m(input logic [BITS-1:0] q);
        longint t;
        t = longint'(q);
        return real'(t) / SCALE;
    endfunction

    function automatic real exp_ang(input real x, input real y);
        return (x == 0.0 && y == 0.0) ? 0.0 : $atan2(y, x);
    endfunction

    function automatic real clamp_mag(input real m);
        return m > MAXR ? MAXR : m;
    endfunction

    function automatic real exp_mag(input real x, input real y);
        return clamp_mag($sqrt(x * x + y * y) * gain);
    endfunction

    task automatic chk_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_real(input string name, input real act, input real exp, input bit wrap);
        real d;
        checks++;
        d = act - exp;
        if (wrap && d > PI_R) d = d - 2.0 * PI_R;
        if (wrap && d < -PI_R) d = d + 2.0 * PI_R;
        if (d > TOL || d < -TOL) begin
            failures++;
            $display("FAIL %s: got %f, expected %f", name, act, exp);
        end
    endtask

    task automatic start(input logic [BITS-1:0] qx, input logic [BITS-1:0] qy);
        @(negedge clk);
        chk_bits("ready before accept", 64'(src_ready), 64'(1));
        src_x = qx;
        src_y = qy;
        src_valid = 1'b1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        src_x = BITS'($urandom());
        src_y = BITS'($urandom());
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 4 * LAT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk_bits($sformatf("%s released", name), {62'b0, res_valid, src_ready}, 64'b01);
    endtask

    task automatic run(input string name, input logic [BITS-1:0] qx, input logic [BITS-1:0] qy);
        int lat;
        start(qx, qy);
        wait_valid(lat);
        chk_bits($sformatf("%s latency", name), 64'(lat), 64'(LAT));
        chk_real($sformatf("%s mag", name), q2m(res_mag), exp_mag(q2r(qx), q2r(qy)), 1'b0);
        chk_real($sformatf("%s angle", name), q2r(res_angle), exp_ang(q2r(qx), q2r(qy)), 1'b1);
        consume(name);
    endtask

    initial begin
        vec_t vecs [7];
        int lat;
        real bx, by;
        vecs[0] = '{0.8, 1.0, 0.896055, 1.280625};
        vecs[1] = '{-0.45, 0.12, 2.880990, 0.465725};
        vecs[2] = '{0.0, -1.0, -1.570796, 1.000000};
        vecs[3] = '{-0.6, 0.0, 3.141593, 0.600000};
        vecs[4] = '{0.0, 0.0, 0.0, 0.0};
        vecs[5] = '{-4.0, -4.0, -2.356194, 5.656854};
        vecs[6] = '{0.6, 0.4, 0.588003, 0.721110};
        gain = 1.0;
`ifndef CORDIC_GAIN_COMP_EN
        for (int j = 0; j < N; j++) gain = gain * $sqrt(1.0 + 2.0 ** (-2 * j));
`endif
        #3;
        chk_bits("in reset handshake", {62'b0, res_valid, src_ready}, 64'b01);
        chk_bits("in reset mag", 64'(res_mag), 64'(0));
        chk_bits("in reset angle", 64'(res_angle), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            start(to_q(vecs[v].x), to_q(vecs[v].y));
            wait_valid(lat);
            chk_bits($sformatf("vec%0d latency", v), 64'(lat), 64'(LAT));
            chk_real($sformatf("vec%0d mag", v), q2m(res_mag), clamp_mag(vecs[v].mag * gain), 1'b0);
            chk_real($sformatf("vec%0d angle", v), q2r(res_angle), vecs[v].ang, 1'b1);
            if (vecs[v].x == 0.0 && vecs[v].y == 0.0) begin
                chk_bits("zero vector mag exact", 64'(res_mag), 64'(0));
                chk_bits("zero vector angle exact", 64'(res_angle), 64'(0));
            end
            if (vecs[v].x == -4.0) chk_bits("most negative saturation", 64'(res_mag), 64'h0_FFFF_FFFF);
            consume($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 24; r++)
            run($sformatf("rand%0d", r), {1'($urandom()), 32'($urandom())}, {1'($urandom()), 32'($urandom())});

        bx = q2r(to_q(0.8));
        by = q2r(to_q(1.0));
        start(to_q(0.8), to_q(1.0));
        wait_valid(lat);
        chk_bits("bp latency", 64'(lat), 64'(LAT));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_bits("bp handshake", {62'b0, res_valid, src_ready}, 64'b10);
            chk_real("bp mag", q2m(res_mag), exp_mag(bx, by), 1'b0);
            chk_real("bp angle", q2r(res_angle), exp_ang(bx, by), 1'b1);
            src_valid = c == 3;
            src_x = to_q(-1.5);
            src_y = to_q(-0.5);
        end
        @(negedge clk);
        src_valid = 1'b0;
        consume("bp");
        repeat (3) @(posedge clk);
        #1;
        chk_bits("bp nothing queued", {62'b0, res_valid, src_ready}, 64'b01);

        start(to_q(-0.3), to_q(0.7));
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bits("mid-run reset handshake", {62'b0, res_valid, src_ready}, 64'b01);
        chk_bits("mid-run reset mag", 64'(res_mag), 64'(0));
        chk_bits("mid-run reset angle", 64'(res_angle), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run("after reset", to_q(0.6), to_q(0.4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
